// File: rtl/traffic_ctrl_param.sv
// Two-road traffic light controller with pedestrian walk phase and flashing night mode.
// Ports: clk_100MHz/reset (async, low), TAORB, ped_req, night_mode in; led, walk, ped_wait, state out.
module traffic_ctrl_param #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 2,
  parameter int MIN_GREEN = 6,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW    = 4,
  parameter int ALLRED    = 2,
  parameter int WALK      = 8
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       TAORB,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [5:0] led,
  output logic       walk,
  output logic       ped_wait,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_AG    = 3'd0,
    S_AY    = 3'd1,
    S_RA    = 3'd2,
    S_BG    = 3'd3,
    S_BY    = 3'd4,
    S_RB    = 3'd5,
    S_WALK  = 3'd6,
    S_NIGHT = 3'd7
  } st_t;

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] P_MAX = CW'(DIV - 1);

  // Timer range also covers fixed phases, so a phase longer than
  // MAX_GREEN can never stall on a saturated timer.
  localparam int M1   = (YELLOW > ALLRED) ? YELLOW : ALLRED;
  localparam int M2   = (M1 > WALK) ? M1 : WALK;
  localparam int TSAT = (M2 > MAX_GREEN) ? M2 : MAX_GREEN;
  localparam int TW   = $clog2(TSAT + 1);

  localparam logic [TW-1:0] T_SAT  = TW'(TSAT);
  localparam logic [TW-1:0] T_MING = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] T_MAXG = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] T_YEL  = TW'(YELLOW - 1);
  localparam logic [TW-1:0] T_RED  = TW'(ALLRED - 1);
  localparam logic [TW-1:0] T_WALK = TW'(WALK - 1);

  st_t           cur;
  st_t           nxt;
  logic [CW-1:0] pcnt;
  logic          tick;
  logic [TW-1:0] timer;
  logic          chg;
  logic          dir_b;
  logic          flash;
  logic          ga_done;
  logic          gb_done;

  // prescaler
  assign tick = (pcnt == P_MAX);

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + CW'(1);
    end
  end

  // phase timer
  assign chg = (nxt != cur);

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (chg) begin
      timer <= '0;
    end else if (tick && timer != T_SAT) begin
      timer <= timer + TW'(1);
    end
  end

  // state register
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      cur <= S_AG;
    end else begin
      cur <= nxt;
    end
  end

  // green may end at MIN_GREEN on cross demand or a waiting
  // pedestrian; it always ends at MAX_GREEN
  assign ga_done = (timer == T_MAXG) ||
                   ((timer >= T_MING) && (!TAORB || ped_wait));
  assign gb_done = (timer == T_MAXG) ||
                   ((timer >= T_MING) && (TAORB || ped_wait));

  // next state
  always_comb begin
    nxt = cur;
    if (tick) begin
      unique case (cur)
        S_AG: begin
          if (ga_done) nxt = S_AY;
        end
        S_AY: begin
          if (timer == T_YEL) nxt = S_RA;
        end
        S_RA: begin
          if (timer == T_RED) begin
            if (night_mode)    nxt = S_NIGHT;
            else if (ped_wait) nxt = S_WALK;
            else               nxt = S_BG;
          end
        end
        S_BG: begin
          if (gb_done) nxt = S_BY;
        end
        S_BY: begin
          if (timer == T_YEL) nxt = S_RB;
        end
        S_RB: begin
          if (timer == T_RED) begin
            if (night_mode)    nxt = S_NIGHT;
            else if (ped_wait) nxt = S_WALK;
            else               nxt = S_AG;
          end
        end
        S_WALK: begin
          if (timer == T_WALK) nxt = dir_b ? S_BG : S_AG;
        end
        S_NIGHT: begin
          if (!night_mode) nxt = S_RB;
        end
        default: nxt = S_AG;
      endcase
    end
  end

  // green that follows the all-red just left; WALK returns to it
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      dir_b <= 1'b0;
    end else if (chg && cur == S_RA) begin
      dir_b <= 1'b1;
    end else if (chg && cur == S_RB) begin
      dir_b <= 1'b0;
    end
  end

  // entering WALK serves the request; a coincident one is absorbed
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      ped_wait <= 1'b0;
    end else if (chg && (nxt == S_WALK || nxt == S_NIGHT)) begin
      ped_wait <= 1'b0;
    end else if (ped_req && cur != S_NIGHT) begin
      ped_wait <= 1'b1;
    end
  end

  // held low outside NIGHT so every night starts dark
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      flash <= 1'b0;
    end else if (cur != S_NIGHT) begin
      flash <= 1'b0;
    end else if (tick) begin
      flash <= ~flash;
    end
  end

  // outputs: {A_R,A_Y,A_G,B_R,B_Y,B_G}
  always_comb begin
    led = 6'b100100;
    unique case (cur)
      S_AG:    led = 6'b001100;
      S_AY:    led = 6'b010100;
      S_BG:    led = 6'b100001;
      S_BY:    led = 6'b100010;
      S_NIGHT: led = {1'b0, flash, 1'b0, flash, 2'b00};
      default: led = 6'b100100;
    endcase
  end

  assign walk  = (cur == S_WALK);
  assign state = cur;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed bench for traffic_ctrl_param with a 4-clock tick.
// Checks phase timing, pedestrian/night paths, resets and lamp safety.
module tb_traffic_ctrl_param;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       TAORB = 1'b1;
  logic       ped_req = 1'b0;
  logic       night_mode = 1'b0;
  logic [5:0] led;
  logic       walk;
  logic       ped_wait;
  logic [2:0] state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic prev_tick = 1'b0;

  traffic_ctrl_param #(
    .CLK_HZ(8), .TICK_HZ(2), .MIN_GREEN(3), .MAX_GREEN(6),
    .YELLOW(2), .ALLRED(1), .WALK(4)
  ) dut (
    .clk_100MHz(clk),
    .reset(reset),
    .TAORB(TAORB),
    .ped_req(ped_req),
    .night_mode(night_mode),
    .led(led),
    .walk(walk),
    .ped_wait(ped_wait),
    .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      total++;
      if ((led[4] | led[3]) && (led[1] | led[0])) begin
        bad++;
        $display("FAIL excl cyc=%0d led=%b need no A and B go", cyc, led);
      end
      total++;
      if (dut.tick && prev_tick) begin
        bad++;
        $display("FAIL tick_width cyc=%0d tick high 2 cycles need 1", cyc);
      end
    end
    prev_tick = dut.tick;
  end

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic go(input int c);
    if (c > cyc) adv(c - cyc);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    ped_req = 1'b0;
    night_mode = 1'b0;
    TAORB = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (state !== 3'd0) begin
      bad++;
      $display("FAIL rst_state got=%0d need=0", state);
    end
    total++;
    if (led !== 6'b001100) begin
      bad++;
      $display("FAIL rst_led got=%b need=001100", led);
    end
    total++;
    if (walk !== 1'b0 || ped_wait !== 1'b0) begin
      bad++;
      $display("FAIL rst_walk got=%b/%b need=0/0", walk, ped_wait);
    end
  endtask

  task automatic test_cycle();
    int cy[13] = '{1, 23, 24, 31, 32, 35, 36, 47, 48, 55, 56, 59, 60};
    logic [2:0] st[13] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 0};
    logic [5:0] ld[13] = '{6'b001100, 6'b001100, 6'b010100, 6'b010100,
                           6'b100100, 6'b100100, 6'b100001, 6'b100001,
                           6'b100010, 6'b100010, 6'b100100, 6'b100100,
                           6'b001100};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      go(cy[i]);
      total++;
      if (state !== st[i] || led !== ld[i]) begin
        bad++;
        $display("FAIL cycle@%0d got st=%0d led=%b need st=%0d led=%b",
                 cy[i], state, led, st[i], ld[i]);
      end
    end
  endtask

  task automatic test_demand();
    int cy[5] = '{11, 12, 24, 47, 48};
    logic [2:0] st[5] = '{0, 1, 3, 3, 4};
    do_reset();
    TAORB = 1'b0;
    for (int i = 0; i < 5; i++) begin
      go(cy[i]);
      total++;
      if (state !== st[i]) begin
        bad++;
        $display("FAIL demand@%0d got st=%0d need st=%0d",
                 cy[i], state, st[i]);
      end
    end
  endtask

  task automatic test_ped();
    do_reset();
    go(1);
    ped_req = 1'b1;
    adv(1);
    ped_req = 1'b0;
    total++;
    if (ped_wait !== 1'b1) begin
      bad++;
      $display("FAIL ped_set got=%b need=1", ped_wait);
    end
    go(11);
    total++;
    if (state !== 3'd0) begin
      bad++;
      $display("FAIL ped_ag got st=%0d need 0", state);
    end
    go(12);
    total++;
    if (state !== 3'd1) begin
      bad++;
      $display("FAIL ped_ay got st=%0d need 1", state);
    end
    go(23);
    total++;
    if (state !== 3'd2 || ped_wait !== 1'b1 || walk !== 1'b0) begin
      bad++;
      $display("FAIL ped_ra got st=%0d pw=%b w=%b need 2/1/0",
               state, ped_wait, walk);
    end
    ped_req = 1'b1;
    adv(1);
    ped_req = 1'b0;
    total++;
    if (state !== 3'd6 || walk !== 1'b1 || led !== 6'b100100 ||
        ped_wait !== 1'b0) begin
      bad++;
      $display("FAIL ped_walk got st=%0d w=%b led=%b pw=%b need 6/1/100100/0",
               state, walk, led, ped_wait);
    end
    go(39);
    total++;
    if (state !== 3'd6 || walk !== 1'b1) begin
      bad++;
      $display("FAIL ped_walk_end got st=%0d w=%b need 6/1", state, walk);
    end
    go(40);
    total++;
    if (state !== 3'd3 || walk !== 1'b0 || led !== 6'b100001) begin
      bad++;
      $display("FAIL ped_bg got st=%0d w=%b led=%b need 3/0/100001",
               state, walk, led);
    end
  endtask

  task automatic test_night();
    int cy[8] = '{35, 36, 39, 40, 44, 47, 48, 52};
    logic [2:0] st[8] = '{2, 7, 7, 7, 7, 7, 5, 0};
    logic [5:0] ld[8] = '{6'b100100, 6'b000000, 6'b000000, 6'b010100,
                          6'b000000, 6'b000000, 6'b100100, 6'b001100};
    do_reset();
    go(1);
    night_mode = 1'b1;
    go(23);
    total++;
    if (state !== 3'd0) begin
      bad++;
      $display("FAIL night_ag got st=%0d need 0", state);
    end
    for (int i = 0; i < 8; i++) begin
      go(cy[i]);
      total++;
      if (state !== st[i] || led !== ld[i]) begin
        bad++;
        $display("FAIL night@%0d got st=%0d led=%b need st=%0d led=%b",
                 cy[i], state, led, st[i], ld[i]);
      end
      if (cy[i] == 36) begin
        go(37);
        ped_req = 1'b1;
        adv(1);
        ped_req = 1'b0;
        total++;
        if (ped_wait !== 1'b0) begin
          bad++;
          $display("FAIL night_ped got=%b need=0", ped_wait);
        end
      end
      if (cy[i] == 44) begin
        go(45);
        night_mode = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    go(1);
    ped_req = 1'b1;
    adv(1);
    ped_req = 1'b0;
    go(25);
    total++;
    if (state !== 3'd6) begin
      bad++;
      $display("FAIL mid_walk got st=%0d need 6", state);
    end
    ped_req = 1'b1;
    adv(1);
    ped_req = 1'b0;
    total++;
    if (ped_wait !== 1'b1) begin
      bad++;
      $display("FAIL mid_pw got=%b need=1", ped_wait);
    end
    reset = 1'b0;
    #1;
    total++;
    if (state !== 3'd0 || led !== 6'b001100 || walk !== 1'b0 ||
        ped_wait !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst got st=%0d led=%b w=%b pw=%b need 0/001100/0/0",
               state, led, walk, ped_wait);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = 0;
    go(2);
    total++;
    if (dut.tick !== 1'b0) begin
      bad++;
      $display("FAIL mid_tick_early got=%b need=0", dut.tick);
    end
    go(3);
    total++;
    if (dut.tick !== 1'b1) begin
      bad++;
      $display("FAIL mid_tick got=%b need=1", dut.tick);
    end
    go(23);
    total++;
    if (state !== 3'd0) begin
      bad++;
      $display("FAIL mid_ag got st=%0d need 0", state);
    end
    go(24);
    total++;
    if (state !== 3'd1) begin
      bad++;
      $display("FAIL mid_ay got st=%0d need 1", state);
    end
  endtask

  initial begin
    test_reset();
    test_cycle();
    test_demand();
    test_ped();
    test_night();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
